// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL reset sequencer: FSM state encoding,
// default parameter values and a counter-width helper.
package pll_seq_pkg;

  localparam int unsigned FILTER_CYCLES_DEF = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned FAULT_HOLD_DEF    = 8;
  localparam int unsigned LOSS_CNT_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } pll_state_e;

  // Bits needed to hold max_val without wrapping (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_reset_seq_lock_filter.sv
// Two-flop synchronizer for the raw PLL lock plus a debounce filter:
// lock is accepted after FILTER_CYCLES consecutive synchronized-high
// cycles and dropped on the first synchronized-low cycle.
module lock_filter
  import pll_seq_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pll_locked_i,
  output logic lock_f_o
);

  localparam int unsigned FW = cnt_width(FILTER_CYCLES);
  localparam logic [FW-1:0] F_ONE  = FW'(1);
  localparam logic [FW-1:0] F_MAX  = FW'(FILTER_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);

  logic          sync1_q;
  logic          lock_s_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          lock_f_q, lock_f_d;

  // Synchronizer chain into the clk domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked_i;
      lock_s_q <= sync1_q;
    end
  end

  // Filter counter saturates at FILTER_CYCLES so lock_f stays asserted.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    lock_f_d   = lock_f_q;
    if (!lock_s_q) begin
      filt_cnt_d = '0;
      lock_f_d   = 1'b0;
    end else if (filt_cnt_q != F_MAX) begin
      filt_cnt_d = filt_cnt_q + F_ONE;
      lock_f_d   = (filt_cnt_q == F_LAST);
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_cnt_q <= '0;
      lock_f_q   <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      lock_f_q   <= lock_f_d;
    end
  end

  assign lock_f_o = lock_f_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: waits for a filtered lock, lets the clock settle,
// then releases the downstream counter stage; a lock loss in RUN forces a
// timed FAULT hold and is counted in a saturating loss counter.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned FAULT_HOLD    = FAULT_HOLD_DEF,
  parameter int unsigned LOSS_CNT_W    = LOSS_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  output logic                  run,
  output logic                  rst_out_n,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
  localparam int unsigned HW = cnt_width(FAULT_HOLD);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_LAST = HW'(FAULT_HOLD - 1);
  localparam logic [LOSS_CNT_W-1:0] L_ONE = LOSS_CNT_W'(1);

  pll_state_e            state_q, state_d;
  logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  lock_f;

  lock_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_lock_filter (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .pll_locked_i(pll_locked),
    .lock_f_o    (lock_f)
  );

  // Next-state logic; counters default to zero outside their own state.
  // A lock loss takes priority over the SETTLE terminal count.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    hold_cnt_d   = '0;
    loss_d       = loss_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_f) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!lock_f)                    state_d = ST_WAIT_LOCK;
        else if (settle_cnt_q == S_LAST) state_d = ST_RUN;
        else                            settle_cnt_d = settle_cnt_q + S_ONE;
      end
      ST_RUN: begin
        if (!lock_f) begin
          state_d = ST_FAULT;
          if (loss_q != '1) loss_d = loss_q + L_ONE;
        end
      end
      ST_FAULT: begin
        if (hold_cnt_q == H_LAST) state_d = ST_WAIT_LOCK;
        else                      hold_cnt_d = hold_cnt_q + H_ONE;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // State, counter and loss-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_LOCK;
      settle_cnt_q <= '0;
      hold_cnt_q   <= '0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      loss_q       <= loss_d;
    end
  end

  assign run        = (state_q == ST_RUN);
  assign rst_out_n  = (state_q == ST_RUN);
  assign state      = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: two instances (default loss width
// and a 2-bit loss counter) share clock, reset and lock stimulus.
// Expected state/loss values are queued against absolute edge numbers.
module tb_pll_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       pll_locked;
  logic       run_a, rstn_a, run_b, rstn_b;
  logic [1:0] state_a, state_b;
  logic [7:0] loss_a;
  logic [1:0] loss_b;

  pll_reset_seq #(
    .FILTER_CYCLES(4),
    .SETTLE_CYCLES(16),
    .FAULT_HOLD   (8),
    .LOSS_CNT_W   (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .run       (run_a),
    .rst_out_n (rstn_a),
    .state     (state_a),
    .loss_count(loss_a)
  );

  pll_reset_seq #(
    .FILTER_CYCLES(4),
    .SETTLE_CYCLES(16),
    .FAULT_HOLD   (8),
    .LOSS_CNT_W   (2)
  ) dut_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .run       (run_b),
    .rst_out_n (rstn_b),
    .state     (state_b),
    .loss_count(loss_b)
  );

  typedef struct {
    int         at;
    string      tag;
    logic [1:0] st;
    int         l1;
    int         l2;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input int at, input string tag, input logic [1:0] st,
                          input int l1, input int l2);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.st  = st;
    e.l1  = l1;
    e.l2  = l2;
    sb.push_back(e);
  endtask

  // Returns at the falling edge following edge number `at`.
  task automatic wait_to(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state_a"}, int'(state_a), 0);
    check_eq({tag, "_run_a"},   int'(run_a),   0);
    check_eq({tag, "_rstn_a"},  int'(rstn_a),  0);
    check_eq({tag, "_loss_a"},  int'(loss_a),  0);
    check_eq({tag, "_state_b"}, int'(state_b), 0);
    check_eq({tag, "_loss_b"},  int'(loss_b),  0);
  endtask

  // Scoreboard consumer: compare every entry due at this edge.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      int   r;
      e = sb.pop_front();
      r = (e.st == 2'd2) ? 1 : 0;
      check_eq({e.tag, "_edge"},    cyc,            e.at);
      check_eq({e.tag, "_state_a"}, int'(state_a),  int'(e.st));
      check_eq({e.tag, "_run_a"},   int'(run_a),    r);
      check_eq({e.tag, "_rstn_a"},  int'(rstn_a),   r);
      check_eq({e.tag, "_loss_a"},  int'(loss_a),   e.l1);
      check_eq({e.tag, "_state_b"}, int'(state_b),  int'(e.st));
      check_eq({e.tag, "_run_b"},   int'(run_b),    r);
      check_eq({e.tag, "_rstn_b"},  int'(rstn_b),   r);
      check_eq({e.tag, "_loss_b"},  int'(loss_b),   e.l2);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, b2, l1, l2;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset_n = 1'b1;
    @(negedge clk);

    // Short 3-cycle lock pulse never satisfies the 4-cycle filter.
    pll_locked = 1'b1;
    b = cyc + 1;
    push_exp(b + 4,  "pulse4",  2'd0, 0, 0);
    push_exp(b + 8,  "pulse8",  2'd0, 0, 0);
    push_exp(b + 15, "pulse15", 2'd0, 0, 0);
    wait_to(b + 2);
    pll_locked = 1'b0;
    wait_to(b + 16);

    // Steady lock: SETTLE after E6, RUN after E(2+4+16)=E22.
    pll_locked = 1'b1;
    b = cyc + 1;
    push_exp(b + 5,  "lock_e5",  2'd0, 0, 0);
    push_exp(b + 6,  "lock_e6",  2'd1, 0, 0);
    push_exp(b + 21, "lock_e21", 2'd1, 0, 0);
    push_exp(b + 22, "lock_e22", 2'd2, 0, 0);
    wait_to(b + 25);

    // Five one-cycle drops from RUN. FAULT after E3, WAIT after E11; lock_f
    // is already back, so SETTLE after E12 and RUN after E28.
    for (int i = 0; i < 5; i++) begin
      l1 = i;
      l2 = (i > 3) ? 3 : i;
      pll_locked = 1'b0;
      b = cyc + 1;
      @(negedge clk);
      pll_locked = 1'b1;
      push_exp(b + 2,  "drop_e2",  2'd2, l1, l2);
      l1 = i + 1;
      l2 = (i + 1 > 3) ? 3 : i + 1;
      push_exp(b + 3,  "drop_e3",  2'd3, l1, l2);
      push_exp(b + 10, "drop_e10", 2'd3, l1, l2);
      push_exp(b + 11, "drop_e11", 2'd0, l1, l2);
      push_exp(b + 27, "drop_e27", 2'd1, l1, l2);
      push_exp(b + 28, "drop_e28", 2'd2, l1, l2);
      wait_to(b + 30);
    end

    // Sixth loss, then asynchronous reset in the middle of FAULT.
    pll_locked = 1'b0;
    b = cyc + 1;
    push_exp(b + 2, "flt_e2", 2'd2, 5, 3);
    push_exp(b + 3, "flt_e3", 2'd3, 6, 3);
    wait_to(b + 5);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Loss at settle count 10 returns to WAIT_LOCK, loss_count untouched.
    pll_locked = 1'b1;
    b = cyc + 1;
    push_exp(b + 5,  "stl_e5",  2'd0, 0, 0);
    push_exp(b + 6,  "stl_e6",  2'd1, 0, 0);
    push_exp(b + 16, "stl_e16", 2'd1, 0, 0);
    wait_to(b + 16);
    pll_locked = 1'b0;
    b2 = cyc + 1;
    push_exp(b2 + 2,  "stl_loss2",  2'd1, 0, 0);
    push_exp(b2 + 3,  "stl_loss3",  2'd0, 0, 0);
    push_exp(b2 + 10, "stl_loss10", 2'd0, 0, 0);
    wait_to(b2 + 11);

    // Loss seen on the same edge as the SETTLE terminal count (E22).
    pll_locked = 1'b1;
    b = cyc + 1;
    push_exp(b + 6,  "tc_e6",  2'd1, 0, 0);
    push_exp(b + 21, "tc_e21", 2'd1, 0, 0);
    wait_to(b + 18);
    pll_locked = 1'b0;
    b2 = cyc + 1;
    push_exp(b2 + 3, "tc_e22", 2'd0, 0, 0);
    push_exp(b2 + 6, "tc_e25", 2'd0, 0, 0);
    wait_to(b2 + 8);

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
